acc_quant_v3: RTL
=================

// Module: acc_quant_v3
// PURPOSE
//  Per-column partial-sum accumulator, requantizer and output stage placed after the systolic
//  array. It accumulates cfg_passes_i skewed psum streams per column (one per K-tile) into an
//  ACC_DEPTH-entry buffer. On the final pass it emits requantized DATA_WIDTH results with
//  rounding shift, saturation and optional ReLU. Depth, pass count, shift and ReLU are
//  runtime-configured per job.
// PARAMETERS
//  PE_SIZE     4   number of columns (independent accumulation lanes)
//  DATA_WIDTH  8   signed output width per column
//  PSUM_WIDTH  32  signed psum/accumulator width
//  ACC_DEPTH   16  accumulator entries per column (output rows per tile); power of 2
//  PASS_W      8   width of pass counter / cfg_passes_i
//  SHIFT_W     5   width of cfg_shift_i
// PORTS
//  clk            in   1                  clock, rising edge
//  rst            in   1                  synchronous reset, active-high
//  start_i        in   1                  latch cfg, begin job (ignored while busy_o=1)
//  cfg_passes_i   in   PASS_W             K-tiles to accumulate, 1..2^PASS_W-1 (0 treated as 1)
//  cfg_rows_i     in   $clog2(ACC_DEPTH)+1 rows per pass, 1..ACC_DEPTH (0 or >ACC_DEPTH -> ACC_DEPTH)
//  cfg_shift_i    in   SHIFT_W            arithmetic right-shift for requantization
//  cfg_relu_i     in   1                  1: clamp negative results to 0
//  psum_valid_i   in   PE_SIZE            per-column psum valid (column skew allowed)
//  psum_row_i     in   PSUM_WIDTH*PE_SIZE column j at bits [PSUM_WIDTH*j +: PSUM_WIDTH]
//  ofmap_row_o    out  DATA_WIDTH*PE_SIZE column j at bits [DATA_WIDTH*j +: DATA_WIDTH]
//  ofmap_valid_o  out  PE_SIZE            per-column output valid, 1-cycle pulse per row
//  busy_o         out  1                  job in progress
//  done_o         out  1                  1-cycle pulse after last column emits last row
//  ovf_o          out  1                  sticky: saturation occurred in accumulate or requant
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; pointers/pass counters 0; buffer contents don't-care.
//  FSM IDLE -> RUN on start_i (cfg latched same edge, busy_o=1 next cycle). RUN -> DONE when all
//   columns finished final pass; DONE -> IDLE after 1 cycle, done_o=1 in DONE.
//  psum_valid_i ignored in IDLE/DONE (no state change). start_i in RUN/DONE ignored.
//  Per column j (independent): row ptr rp[j] 0..rows-1, pass ctr pc[j] 0..passes-1.
//   On psum_valid_i[j]: acc = (pc==0 ? 0 : buf[j][rp]) + psum, signed saturating to PSUM_WIDTH.
//   If pc<passes-1: buf[j][rp]<=acc. If pc==passes-1: acc goes to output stage, not written back.
//   rp increments; at rows-1 wraps to 0 and pc increments. After final wrap, column is finished;
//   further valids ignored until next job.
//  Read-modify-write same cycle; back-to-back valids on the same column every cycle supported.
//  Requant (registered, latency 1: valid at cycle t -> ofmap_valid_o[j] at t+1):
//   r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift  (round half up, arithmetic)
//   saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; if relu and r<0 -> 0.
//  ofmap data holds last value when not valid. ovf_o set on any saturation, cleared only by
//   start_i accepted or rst.
//  rst in RUN: aborts job immediately; no done_o; all outputs 0 next cycle.
//  passes=1: no buffer read (feedback 0), every psum directly requantized.
// TESTING
//  passes=1, rows=4, shift=0, psums 1,2,3,4 col0 -> ofmap col0 1,2,3,4 one cycle later; done_o.
//  passes=3, rows=2, shift=2, each pass psum=10 col all -> outputs (30+2)>>>2=8 per row, only last pass.
//  Skew: col j valid delayed j cycles, passes=2, rows=ACC_DEPTH -> per-column pulses skewed by j; one done_o.
//  psum=200, shift=0 -> out 127, ovf_o=1; psum=-5 relu=1 -> out 0, ovf_o unchanged.
//  Accumulate 0x7FFFFFF0+0x100 over 2 passes -> acc saturates 0x7FFFFFFF, ovf_o=1.
//  rst asserted mid-pass 2 -> busy_o=0, outputs 0; new job with passes=1 gives fresh results.

Source files
------------

// File: rtl/acc_quant_v3.sv
// Per-column psum accumulator with rounding requantizer, saturation and ReLU.
// Accumulates several K-tile passes per column, then emits DATA_WIDTH results.
module acc_quant_v3 #(
    parameter int PE_SIZE    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 32,
    parameter int ACC_DEPTH  = 16,
    parameter int PASS_W     = 8,
    parameter int SHIFT_W    = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic [PASS_W-1:0]                cfg_passes_i,
    input  logic [$clog2(ACC_DEPTH):0]       cfg_rows_i,
    input  logic [SHIFT_W-1:0]               cfg_shift_i,
    input  logic                             cfg_relu_i,
    input  logic [PE_SIZE-1:0]               psum_valid_i,
    input  logic [PSUM_WIDTH*PE_SIZE-1:0]    psum_row_i,
    output logic [DATA_WIDTH*PE_SIZE-1:0]    ofmap_row_o,
    output logic [PE_SIZE-1:0]               ofmap_valid_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             ovf_o
);

    localparam int AW = $clog2(ACC_DEPTH);
    localparam int PW = PSUM_WIDTH;
    localparam int DW = DATA_WIDTH;

    localparam logic [AW:0]        ROWS_MAX = (AW+1)'(ACC_DEPTH);
    localparam logic [AW:0]        ROW_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]      RP_ONE   = AW'(1);
    localparam logic [PASS_W-1:0]  PC_ONE   = PASS_W'(1);
    localparam logic [SHIFT_W-1:0] SH_ONE   = SHIFT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [PASS_W-1:0]   r_passes;
    logic [AW:0]         r_rows;
    logic [SHIFT_W-1:0]  r_shift;
    logic                r_relu;
    logic                r_busy;
    logic                r_done;
    logic                r_ovf;

    logic                w_accept;
    logic                w_run;
    logic [PASS_W-1:0]   w_passes_n;
    logic [AW:0]         w_rows_n;
    logic [PE_SIZE-1:0]  w_fin;
    logic [PE_SIZE-1:0]  w_sat;

    assign w_accept = start_i && (r_state == S_IDLE);
    assign w_run    = (r_state == S_RUN);

    // Out-of-range job sizes fall back to the nearest legal value.
    always_comb begin
        w_passes_n = cfg_passes_i;
        if (cfg_passes_i == '0) begin
            w_passes_n = PC_ONE;
        end
        w_rows_n = cfg_rows_i;
        if (cfg_rows_i == '0 || cfg_rows_i > ROWS_MAX) begin
            w_rows_n = ROWS_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_passes <= '0;
            r_rows   <= '0;
            r_shift  <= '0;
            r_relu   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_ovf <= 1'b0;
            end else if (|w_sat) begin
                r_ovf <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_passes <= w_passes_n;
                        r_rows   <= w_rows_n;
                        r_shift  <= cfg_shift_i;
                        r_relu   <= cfg_relu_i;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (&w_fin) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign ovf_o  = r_ovf;

    for (genvar j = 0; j < PE_SIZE; j++) begin : g_col
        logic [PW-1:0]          r_buf [ACC_DEPTH];
        logic [AW-1:0]          r_rp;
        logic [PASS_W-1:0]      r_pc;
        logic                   r_fin;
        logic                   r_oval;
        logic [DW-1:0]          r_q;

        logic                   w_hit;
        logic                   w_first;
        logic                   w_last;
        logic                   w_wrap;
        logic                   w_acc_ovf;
        logic                   w_q_ovf;
        logic [PW-1:0]          w_psum;
        logic [PW-1:0]          w_fb;
        logic [PW-1:0]          w_acc;
        logic signed [PW:0]     w_sum;
        logic signed [PW:0]     w_rc;
        logic signed [PW:0]     w_rnd;
        logic signed [PW:0]     w_shr;
        logic [PW-DW+1:0]       w_hi;
        logic [DW-1:0]          w_q;

        assign w_psum  = psum_row_i[PW*j +: PW];
        assign w_hit   = w_run && psum_valid_i[j] && !r_fin;
        assign w_first = (r_pc == '0);
        assign w_last  = (r_pc == r_passes - PC_ONE);
        assign w_wrap  = ({1'b0, r_rp} == r_rows - ROW_ONE);
        assign w_fb    = w_first ? '0 : r_buf[r_rp];

        always_comb begin
            w_sum     = {w_fb[PW-1], w_fb} + {w_psum[PW-1], w_psum};
            w_acc_ovf = (w_sum[PW] != w_sum[PW-1]);
            w_acc     = w_sum[PW-1:0];
            if (w_acc_ovf) begin
                w_acc = w_sum[PW] ? {1'b1, {(PW-1){1'b0}}}
                                  : {1'b0, {(PW-1){1'b1}}};
            end
            // One guard bit keeps the rounding add from wrapping.
            w_rc = '0;
            if (r_shift != '0) begin
                w_rc = (PW+1)'(1) << (r_shift - SH_ONE);
            end
            w_rnd   = {w_acc[PW-1], w_acc} + w_rc;
            w_shr   = w_rnd >>> r_shift;
            w_hi    = w_shr[PW:DW-1];
            w_q_ovf = !((w_hi == '0) || (&w_hi));
            w_q     = w_shr[DW-1:0];
            if (w_q_ovf) begin
                w_q = w_shr[PW] ? {1'b1, {(DW-1){1'b0}}}
                                : {1'b0, {(DW-1){1'b1}}};
            end
            if (r_relu && w_q[DW-1]) begin
                w_q = '0;
            end
        end

        assign w_sat[j] = w_hit && (w_acc_ovf || (w_last && w_q_ovf));
        assign w_fin[j] = r_fin;

        always_ff @(posedge clk) begin
            if (w_hit && !w_last) begin
                r_buf[r_rp] <= w_acc;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rp   <= '0;
                r_pc   <= '0;
                r_fin  <= 1'b0;
                r_oval <= 1'b0;
                r_q    <= '0;
            end else begin
                r_oval <= w_hit && w_last;
                if (w_accept) begin
                    r_rp  <= '0;
                    r_pc  <= '0;
                    r_fin <= 1'b0;
                end else if (w_hit) begin
                    if (w_last) begin
                        r_q <= w_q;
                    end
                    if (w_wrap) begin
                        r_rp <= '0;
                        r_pc <= r_pc + PC_ONE;
                        if (w_last) begin
                            r_fin <= 1'b1;
                        end
                    end else begin
                        r_rp <= r_rp + RP_ONE;
                    end
                end
            end
        end

        assign ofmap_row_o[DW*j +: DW] = r_q;
        assign ofmap_valid_o[j]        = r_oval;
    end

endmodule
